lc3_regfile: RTL and testbench
==============================

// Module: lc3_regfile
// PURPOSE
//   LC-3 general-purpose register file: consumer end of the destination-register select path.
//   Accepts a resolved 3-bit DR (IR[11:9] or R7) plus bus data as the write port.
//   Provides two source read ports (SR1 via internal SR1MUX, SR2 = IR[2:0]).
//   Also holds the NZP condition-code register and a handshaked debug dump channel (R0..R7).
//   The dump channel streams registers to the FPGA debug/display logic.
// PARAMETERS
//   DATA_W  16  register/bus width
//   BYPASS  1   1: write data forwarded to SR1/SR2 reads of the same register in the same cycle; 0: no forward
// PORTS
//   Clk         in   1       system clock, all state on rising edge
//   Reset       in   1       synchronous, active-high
//   ld_reg      in   1       write enable for register file
//   dr          in   3       destination register index (from DR select)
//   bus_in      in   DATA_W  write data / CC source (CPU bus)
//   ir          in   16      instruction register
//   sr1_sel     in   1       0: SR1 = ir[11:9], 1: SR1 = ir[8:6]
//   sr1_out     out  DATA_W  R[SR1], combinational
//   sr2_out     out  DATA_W  R[ir[2:0]], combinational
//   ld_cc       in   1       load NZP from bus_in
//   nzp         out  3       {N,Z,P} condition codes, registered
//   dump_req    in   1       start dump (sampled in IDLE only)
//   dump_valid  out  1       dump_data/dump_idx valid
//   dump_ready  in   1       sink accepts current word
//   dump_idx    out  3       index of word presented
//   dump_data   out  DATA_W  R[dump_idx]
//   dump_busy   out  1       high from dump start until final transfer
//   dump_done   out  1       one-cycle pulse, cycle after final transfer
// BEHAVIOUR
//   Reset (sync): R0..R7 = 0; nzp = 3'b010; FSM = IDLE; dump_idx = 0; valid/busy/done = 0.
//   Reset has priority over ld_reg, ld_cc, and any dump in progress; an aborted dump produces no dump_done.
//   Write: ld_reg=1 at edge -> R[dr] <= bus_in; visible on reads next cycle (same cycle if BYPASS=1 and index matches).
//   Reads: 0-cycle latency, pure mux of register array (+ bypass). SR1 and SR2 are allowed to be equal.
//   CC: ld_cc=1 at edge -> nzp <= bus_in[15] ? 100 : (bus_in==0 ? 010 : 001); exactly one bit is set.
//   ld_cc and ld_reg are independent; both can be asserted in the same cycle.
//   Dump FSM states: IDLE, SEND, DONE.
//     IDLE: dump_req=1 -> SEND, dump_idx=0, busy=1.
//     SEND: valid=1; dump_data = R[dump_idx] (array value, no bypass).
//       valid&ready with idx<7 -> idx++; with idx==7 -> DONE.
//       !ready -> hold idx; data may change only if that register is written (it tracks the array).
//     DONE: done=1, busy=0, valid=0, idx=0 -> IDLE next cycle.
//   dump_req is ignored outside IDLE; a held-high req restarts a dump after DONE.
//   Minimum dump: 8 transfer cycles + 1 DONE cycle with ready tied high.
//   Dump never stalls or alters CPU writes/reads.
// TESTING
//   Reset, then read all: sr1/sr2 = 0x0000 for every index; nzp=010.
//   ld_reg dr=7 bus=0x1234; ir[8:6]=7, sr1_sel=1 -> sr1_out=0x1234 next cycle (same cycle if BYPASS=1).
//   ld_cc bus=0x8000 -> nzp=100; bus=0 -> 010; bus=0x7FFF -> 001.
//   Load R0..R7=0x0010*k; dump with ready=1 -> idx 0..7, data 0x0000..0x0070, done pulse at cycle 9.
//   Dump with ready toggling 1/0 -> no skipped or repeated idx; write R3=0xBEEF while idx=3 stalled -> data=0xBEEF next cycle.
//   Reset asserted at idx=4 -> valid/busy=0 next cycle, no dump_done, all regs=0.

Source files
------------

// File: rtl/lc3_regfile.sv
// lc3_regfile: LC-3 general-purpose register file with NZP condition codes
// and a handshaked debug dump channel that streams R0..R7 to display logic.
//
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   ld_reg, dr, bus_in  write port (R[dr] <= bus_in)
//   ir, sr1_sel         source selects: SR1 = ir[11:9] or ir[8:6], SR2 = ir[2:0]
//   sr1_out, sr2_out    combinational read data (optionally bypassed)
//   ld_cc, nzp          condition-code load and registered {N,Z,P}
//   dump_req/valid/ready/idx/data/busy/done   debug dump channel
module lc3_regfile #(
  parameter int unsigned DATA_W = 16,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ld_reg,
  input  logic [2:0]        dr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [15:0]       ir,
  input  logic              sr1_sel,
  output logic [DATA_W-1:0] sr1_out,
  output logic [DATA_W-1:0] sr2_out,
  input  logic              ld_cc,
  output logic [2:0]        nzp,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [2:0]        dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } dump_state_t;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [2:0]        r_nzp;
  dump_state_t       r_state;
  logic [IDX_W-1:0]  r_dump_idx;
  logic              r_dump_valid;
  logic              r_dump_busy;
  logic              r_dump_done;

  logic [IDX_W-1:0]  w_sr1_idx;
  logic [IDX_W-1:0]  w_sr2_idx;
  logic [2:0]        w_nzp_next;
  logic              w_unused_ir;

  // Opcode and the ir[5:3] field are decoded elsewhere.
  assign w_unused_ir = ^{ir[15:12], ir[5:3]};

  // Source register selection.
  assign w_sr1_idx = sr1_sel ? ir[8:6] : ir[11:9];
  assign w_sr2_idx = ir[2:0];

  // Reads: array mux, with same-cycle forwarding of a matching write when enabled.
  assign sr1_out = (BYPASS && ld_reg && (dr == w_sr1_idx)) ? bus_in : r_regs[w_sr1_idx];
  assign sr2_out = (BYPASS && ld_reg && (dr == w_sr2_idx)) ? bus_in : r_regs[w_sr2_idx];

  // Register array write port.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (ld_reg) begin
      r_regs[dr] <= bus_in;
    end
  end

  // Condition-code encode: sign first, then zero, otherwise positive.
  always_comb begin
    w_nzp_next = 3'b001;
    if (bus_in[DATA_W-1]) begin
      w_nzp_next = 3'b100;
    end else if (bus_in == '0) begin
      w_nzp_next = 3'b010;
    end
  end

  // Condition-code register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_nzp <= 3'b010;
    end else if (ld_cc) begin
      r_nzp <= w_nzp_next;
    end
  end

  assign nzp = r_nzp;

  // Dump FSM: walks R0..R7 under valid/ready, then a one-cycle DONE pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_dump_idx   <= '0;
      r_dump_valid <= 1'b0;
      r_dump_busy  <= 1'b0;
      r_dump_done  <= 1'b0;
    end else begin
      r_dump_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dump_req) begin
            r_state      <= S_SEND;
            r_dump_idx   <= '0;
            r_dump_valid <= 1'b1;
            r_dump_busy  <= 1'b1;
          end
        end
        S_SEND: begin
          if (r_dump_valid && dump_ready) begin
            if (r_dump_idx == IDX_W'(NUM_REGS - 1)) begin
              r_state      <= S_DONE;
              r_dump_idx   <= '0;
              r_dump_valid <= 1'b0;
              r_dump_busy  <= 1'b0;
              r_dump_done  <= 1'b1;
            end else begin
              r_dump_idx <= r_dump_idx + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state      <= S_IDLE;
          r_dump_idx   <= '0;
          r_dump_valid <= 1'b0;
          r_dump_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dump_valid = r_dump_valid;
  assign dump_idx   = r_dump_idx;
  assign dump_busy  = r_dump_busy;
  assign dump_done  = r_dump_done;
  // Dump data tracks the array directly, never the bypass path.
  assign dump_data  = r_regs[r_dump_idx];

endmodule

// File: tb/tb_lc3_regfile.sv
// tb_lc3_regfile: self-checking bench for lc3_regfile (DATA_W=16, BYPASS=1).
// Dump words are queued as expected {idx,data} pairs and retired on handshakes.
module tb_lc3_regfile;

  localparam int unsigned DATA_W = 16;

  logic              Clk;
  logic              Reset;
  logic              ld_reg;
  logic [2:0]        dr;
  logic [DATA_W-1:0] bus_in;
  logic [15:0]       ir;
  logic              sr1_sel;
  logic [DATA_W-1:0] sr1_out;
  logic [DATA_W-1:0] sr2_out;
  logic              ld_cc;
  logic [2:0]        nzp;
  logic              dump_req;
  logic              dump_valid;
  logic              dump_ready;
  logic [2:0]        dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_busy;
  logic              dump_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] model [8];
  logic [18:0]       sb_q [$];

  lc3_regfile #(.DATA_W(DATA_W), .BYPASS(1'b1)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ld_reg     (ld_reg),
    .dr         (dr),
    .bus_in     (bus_in),
    .ir         (ir),
    .sr1_sel    (sr1_sel),
    .sr1_out    (sr1_out),
    .sr2_out    (sr2_out),
    .ld_cc      (ld_cc),
    .nzp        (nzp),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Point SR1 (via sr1_sel) and SR2 at given registers.
  task automatic set_srcs(input logic [2:0] s1, input logic sel, input logic [2:0] s2);
    ir      = {4'h0, s1, s1, 3'b000, s2};
    sr1_sel = sel;
    #1;
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
    ld_reg = 1'b1;
    dr     = idx;
    bus_in = val;
    tick();
    ld_reg = 1'b0;
    model[idx] = val;
  endtask

  // Expected CC encoding, written independently of the DUT.
  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if (v[15])       return 3'b100;
    else if (v == 0) return 3'b010;
    else             return 3'b001;
  endfunction

  initial begin
    logic [15:0] cc_vals [4];
    logic [18:0] exp_e;
    int          done_at;
    bit          wrote;
    bit          stall_seen;
    bit          reached;

    Reset = 1'b1; ld_reg = 1'b0; dr = 3'd0; bus_in = '0; ir = '0; sr1_sel = 1'b0;
    ld_cc = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    tick();
    tick();
    Reset = 1'b0;

    // Reset state
    check("rst_nzp",   32'(nzp), 32'(3'b010));
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_busy",  32'(dump_busy), 32'd0);
    check("rst_done",  32'(dump_done), 32'd0);
    check("rst_idx",   32'(dump_idx), 32'd0);
    for (int k = 0; k < 8; k++) begin
      set_srcs(3'(k), k[0], 3'(k));
      check("rst_sr1", 32'(sr1_out), 32'd0);
      check("rst_sr2", 32'(sr2_out), 32'd0);
    end

    // Write R7 with same-cycle forwarding, then from the array
    set_srcs(3'd7, 1'b1, 3'd7);
    ld_reg = 1'b1; dr = 3'd7; bus_in = 16'h1234;
    #1;
    check("byp_sr1", 32'(sr1_out), 32'h1234);
    check("byp_sr2", 32'(sr2_out), 32'h1234);
    tick();
    ld_reg = 1'b0; bus_in = 16'h0;
    model[7] = 16'h1234;
    #1;
    check("wr_sr1", 32'(sr1_out), 32'h1234);
    set_srcs(3'd7, 1'b0, 3'd0);
    check("wr_sr1_sel0", 32'(sr1_out), 32'h1234);
    check("wr_sr2_r0",   32'(sr2_out), 32'h0);

    // Condition codes; the last one loads alongside a register write
    cc_vals[0] = 16'h8000; cc_vals[1] = 16'h0000; cc_vals[2] = 16'hFFFF; cc_vals[3] = 16'h7FFF;
    for (int k = 0; k < 4; k++) begin
      ld_cc = 1'b1; bus_in = cc_vals[k];
      if (k == 3) begin ld_reg = 1'b1; dr = 3'd5; end
      tick();
      ld_cc = 1'b0; ld_reg = 1'b0;
      if (k == 3) model[5] = cc_vals[k];
      check("nzp", 32'(nzp), 32'(cc_of(cc_vals[k])));
    end
    set_srcs(3'd5, 1'b1, 3'd5);
    check("cc_and_reg", 32'(sr2_out), 32'h7FFF);

    // Load R0..R7 = 0x10*k and read each back
    for (int k = 0; k < 8; k++) write_reg(3'(k), 16'(16'h0010 * k));
    for (int k = 0; k < 8; k++) begin
      set_srcs(3'(k), 1'b0, 3'(7 - k));
      check("ld_sr1", 32'(sr1_out), 32'(model[k]));
      check("ld_sr2", 32'(sr2_out), 32'(model[7 - k]));
    end

    // Dump with ready tied high
    for (int k = 0; k < 8; k++) sb_q.push_back({3'(k), model[k]});
    dump_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    done_at = 0;
    for (int c = 1; c <= 14; c++) begin
      if (dump_valid) check("busy_in_send", 32'(dump_busy), 32'd1);
      if (dump_valid && dump_ready) begin
        if (sb_q.size() == 0) begin
          check("extra_word", 32'd1, 32'd0);
        end else begin
          exp_e = sb_q.pop_front();
          check("dump1_idx",  32'(dump_idx),  32'(exp_e[18:16]));
          check("dump1_data", 32'(dump_data), 32'(exp_e[15:0]));
        end
      end
      if (dump_done) begin
        check("done_busy",  32'(dump_busy), 32'd0);
        check("done_valid", 32'(dump_valid), 32'd0);
        if (done_at == 0) done_at = c;
      end
      tick();
    end
    check("done_cycle", 32'(done_at), 32'd9);
    check("dump1_left", 32'(sb_q.size()), 32'd0);
    sb_q.delete();

    // Dump with ready toggling; R3 is rewritten while stalled at idx 3
    for (int k = 0; k < 8; k++) sb_q.push_back({3'(k), (k == 3) ? 16'hBEEF : model[k]});
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wrote = 1'b0; stall_seen = 1'b0; done_at = 0;
    for (int c = 1; c <= 30; c++) begin
      dump_ready = c[0];
      #1;
      if (dump_valid) begin
        if (sb_q.size() == 0) begin
          check("extra_word2", 32'd1, 32'd0);
        end else begin
          exp_e = sb_q[0];
          check("dump2_idx", 32'(dump_idx), 32'(exp_e[18:16]));
          if (dump_ready) begin
            exp_e = sb_q.pop_front();
            check("dump2_data", 32'(dump_data), 32'(exp_e[15:0]));
          end
        end
      end
      if (dump_done && done_at == 0) done_at = c;
      if (dump_valid && !dump_ready && dump_idx == 3'd3 && !wrote) begin
        check("stall_old_data", 32'(dump_data), 32'h0030);
        ld_reg = 1'b1; dr = 3'd3; bus_in = 16'hBEEF;
        wrote = 1'b1; stall_seen = 1'b1;
      end
      tick();
      if (ld_reg) begin
        ld_reg = 1'b0;
        model[3] = 16'hBEEF;
      end
    end
    check("stall_seen", 32'(stall_seen), 32'd1);
    check("dump2_done", 32'(done_at != 0), 32'd1);
    check("dump2_left", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    set_srcs(3'd3, 1'b0, 3'd3);
    check("r3_after", 32'(sr1_out), 32'hBEEF);

    // Reset in the middle of a dump at idx 4
    dump_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 12 && !reached; c++) begin
      if (dump_valid && dump_idx == 3'd4) reached = 1'b1;
      else tick();
    end
    check("reach_idx4", 32'(reached), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_valid", 32'(dump_valid), 32'd0);
    check("abort_busy",  32'(dump_busy), 32'd0);
    check("abort_idx",   32'(dump_idx), 32'd0);
    check("abort_nzp",   32'(nzp), 32'(3'b010));
    done_at = 0;
    for (int c = 0; c < 12; c++) begin
      if (dump_done || dump_valid) done_at = 1;
      tick();
    end
    check("abort_no_done", 32'(done_at), 32'd0);
    for (int k = 0; k < 8; k++) begin
      set_srcs(3'(k), 1'b1, 3'(k));
      check("abort_regs", 32'(sr1_out), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
